// File: rtl/arb_pkg.sv
// Shared arbiter types: FSM state encoding, master id and the core's mode constants.
package arb_pkg;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t IDLE = 2'd0;
  localparam arb_state_t BUSY = 2'd1;
  localparam arb_state_t DONE = 2'd2;

  typedef logic master_id_t;

  localparam logic [2:0] MODE_FETCH = 3'b111;

  function automatic logic [1:0] id_onehot(input master_id_t id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational winner selection between two requesters, round-robin or fixed priority.
module arb_rr_pick
  import arb_pkg::*;
(
  input  logic [1:0] req,
  input  master_id_t rr_last,
  input  logic       fixed,
  output master_id_t winner,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    winner = req[1];
    // On contention, fixed mode favours M0; otherwise whoever was not served last.
    if (req == 2'b11)
      winner = fixed ? 1'b0 : ~rr_last;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master memory port arbiter, one whole transaction at a time.
// Define ARB_TIMEOUT_EN to abort slave transactions that exceed TIMEOUT cycles.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        m_req,
  input  logic [1:0]        m_wen,
  input  logic [5:0]        m_mode,
  input  logic [2*XLEN-1:0] m_addr,
  input  logic [2*XLEN-1:0] m_wdat,
  output logic [2*XLEN-1:0] m_rdat,
  output logic [1:0]        m_ready,
  output logic [1:0]        m_err,
  output logic              s_req,
  output logic              s_wen,
  output logic [2:0]        s_mode,
  output logic [XLEN-1:0]   s_addr,
  output logic [XLEN-1:0]   s_wdat,
  input  logic [XLEN-1:0]   s_rdat,
  input  logic              s_ready,
  output logic              grant_id
);

  arb_state_t state;
  master_id_t rr_last;
  master_id_t pick_id;
  logic       pick_valid;
  logic       timed_out;

  arb_rr_pick u_pick (
    .req     (m_req),
    .rr_last (rr_last),
    .fixed   (FIXED_PRIO != 0),
    .winner  (pick_id),
    .valid   (pick_valid)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] busy_cnt;
  logic [1:0]       err_q;

  // Counter sits at zero outside BUSY, so it starts fresh on every grant.
  always_ff @(posedge clk) begin
    if (!rst || state != BUSY)
      busy_cnt <= '0;
    else
      busy_cnt <= busy_cnt + 1'b1;
  end

  assign timed_out = (busy_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst)
      err_q <= 2'b00;
    else if (state == BUSY && !s_ready && timed_out)
      err_q <= id_onehot(grant_id);
    else if (state == DONE)
      err_q <= 2'b00;
  end

  assign m_err = err_q;
`else
  assign timed_out = 1'b0;
  assign m_err     = 2'b00;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      s_req    <= 1'b0;
      s_wen    <= 1'b0;
      s_mode   <= 3'b000;
      s_addr   <= '0;
      s_wdat   <= '0;
      m_ready  <= 2'b00;
      m_rdat   <= '0;
      grant_id <= 1'b0;
      rr_last  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            s_wen    <= pick_id ? m_wen[1] : m_wen[0];
            s_mode   <= pick_id ? m_mode[5:3] : m_mode[2:0];
            s_addr   <= pick_id ? m_addr[2*XLEN-1:XLEN] : m_addr[XLEN-1:0];
            s_wdat   <= pick_id ? m_wdat[2*XLEN-1:XLEN] : m_wdat[XLEN-1:0];
            s_req    <= 1'b1;
            grant_id <= pick_id;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (s_ready) begin
            s_req   <= 1'b0;
            s_wen   <= 1'b0;
            m_ready <= id_onehot(grant_id);
            rr_last <= grant_id;
            if (grant_id) m_rdat[2*XLEN-1:XLEN] <= s_rdat;
            else          m_rdat[XLEN-1:0]      <= s_rdat;
            state   <= DONE;
          end else if (timed_out) begin
            // Aborted transactions return zero data and do not advance round-robin.
            s_req   <= 1'b0;
            m_ready <= id_onehot(grant_id);
            if (grant_id) m_rdat[2*XLEN-1:XLEN] <= '0;
            else          m_rdat[XLEN-1:0]      <= '0;
            state   <= DONE;
          end
        end
        DONE: begin
          m_ready <= 2'b00;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic vs a transaction model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_req, m_wen, m_ready, m_err;
  logic [5:0]  m_mode;
  logic [63:0] m_addr, m_wdat, m_rdat;
  logic        s_req, s_wen, s_ready, grant_id;
  logic [2:0]  s_mode;
  logic [31:0] s_addr, s_wdat, s_rdat;

  logic [1:0]  f_m_req, f_m_wen, f_m_ready, f_m_err;
  logic [5:0]  f_m_mode;
  logic [63:0] f_m_addr, f_m_wdat, f_m_rdat;
  logic        f_s_req, f_s_wen, f_s_ready, f_grant_id;
  logic [2:0]  f_s_mode;
  logic [31:0] f_s_addr, f_s_wdat, f_s_rdat;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.XLEN(32), .FIXED_PRIO(0), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_wen(m_wen), .m_mode(m_mode),
    .m_addr(m_addr), .m_wdat(m_wdat), .m_rdat(m_rdat), .m_ready(m_ready),
    .m_err(m_err), .s_req(s_req), .s_wen(s_wen), .s_mode(s_mode),
    .s_addr(s_addr), .s_wdat(s_wdat), .s_rdat(s_rdat), .s_ready(s_ready),
    .grant_id(grant_id)
  );

  mem_arbiter #(.XLEN(32), .FIXED_PRIO(1), .TIMEOUT(4)) dut_f (
    .clk(clk), .rst(rst), .m_req(f_m_req), .m_wen(f_m_wen), .m_mode(f_m_mode),
    .m_addr(f_m_addr), .m_wdat(f_m_wdat), .m_rdat(f_m_rdat), .m_ready(f_m_ready),
    .m_err(f_m_err), .s_req(f_s_req), .s_wen(f_s_wen), .s_mode(f_s_mode),
    .s_addr(f_s_addr), .s_wdat(f_s_wdat), .s_rdat(f_s_rdat), .s_ready(f_s_ready),
    .grant_id(f_grant_id)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    m_req = 0; m_wen = 0; m_mode = 0; m_addr = 0; m_wdat = 0; s_rdat = 0; s_ready = 0;
    f_m_req = 0; f_m_wen = 0; f_m_mode = 0; f_m_addr = 0; f_m_wdat = 0; f_s_rdat = 0; f_s_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    m_req = 2'b11; f_m_req = 2'b11;
    rst = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({s_req, s_wen, s_mode, s_addr, s_wdat} !== 69'd0) begin
      n_bad++; $display("[TB] FAIL reset_slave: got %h expected 0", {s_req, s_wen, s_mode, s_addr, s_wdat});
    end
    n_cmp++;
    if ({m_ready, m_err, m_rdat} !== 68'd0) begin
      n_bad++; $display("[TB] FAIL reset_master: got %h expected 0", {m_ready, m_err, m_rdat});
    end
    n_cmp++;
    if (grant_id !== 1'b0 || f_s_req !== 1'b0) begin
      n_bad++; $display("[TB] FAIL reset_grant: got %b/%b expected 0/0", grant_id, f_s_req);
    end
    m_req = 0; f_m_req = 0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_m0_read();
    int sc = 0, rc = 0;
    logic [31:0] got = 0;
    m_req = 2'b01; m_wen = 0; m_mode = 6'b000_010;
    m_addr = {32'h0, 32'h8000_0000}; s_rdat = 32'hDEAD_BEEF;
    for (int c = 0; c < 20; c++) begin
      tick();
      s_ready = 0;
      if (s_req) begin
        sc++;
        if (sc == 1) begin
          n_cmp++;
          if (s_addr !== 32'h8000_0000 || grant_id !== 1'b0) begin
            n_bad++; $display("[TB] FAIL m0_read_addr: got %h/%b expected 80000000/0", s_addr, grant_id);
          end
        end
        if (sc == 3) s_ready = 1;
      end
      if (m_ready[0]) begin rc++; got = m_rdat[31:0]; m_req = 0; end
      if (m_ready[1]) rc += 100;
    end
    n_cmp++;
    if (sc !== 3) begin n_bad++; $display("[TB] FAIL m0_read_sreq_cycles: got %0d expected 3", sc); end
    n_cmp++;
    if (rc !== 1) begin n_bad++; $display("[TB] FAIL m0_read_ready_count: got %0d expected 1", rc); end
    n_cmp++;
    if (got !== 32'hDEAD_BEEF) begin n_bad++; $display("[TB] FAIL m0_read_rdat: got %h expected deadbeef", got); end
  endtask

  task automatic test_back_to_back();
    int seq[$];
    int last_c = -1;
    int g;
    logic [31:0] last_rd = 0;
    do_reset();
    m_req = 2'b11;
    for (int c = 0; c < 60 && seq.size() < 6; c++) begin
      tick();
      if (m_ready != 2'b00) begin
        g = m_ready[1] ? 1 : 0;
        n_cmp++;
        if (g !== seq.size() % 2 || m_ready === 2'b11) begin
          n_bad++; $display("[TB] FAIL rr_grant_%0d: got %b expected master %0d", seq.size(), m_ready, seq.size() % 2);
        end
        n_cmp++;
        if (m_rdat[g*32 +: 32] !== last_rd) begin
          n_bad++; $display("[TB] FAIL rr_rdat_%0d: got %h expected %h", seq.size(), m_rdat[g*32 +: 32], last_rd);
        end
        if (last_c >= 0) begin
          n_cmp++;
          if (c - last_c !== 3) begin
            n_bad++; $display("[TB] FAIL rr_spacing: got %0d expected 3", c - last_c);
          end
        end
        last_c = c;
        seq.push_back(g);
      end
      s_ready = s_req;
      s_rdat = $urandom;
      last_rd = s_rdat;
    end
    n_cmp++;
    if (seq.size() !== 6) begin n_bad++; $display("[TB] FAIL rr_count: got %0d expected 6", seq.size()); end
    m_req = 0; s_ready = 0;
    tick(); tick(); tick();
  endtask

  task automatic test_fixed_prio();
    int exp_seq[4] = '{0, 0, 0, 1};
    int n = 0;
    int g;
    do_reset();
    f_m_req = 2'b11;
    for (int c = 0; c < 60 && n < 4; c++) begin
      tick();
      if (f_m_ready != 2'b00) begin
        g = f_m_ready[1] ? 1 : 0;
        n_cmp++;
        if (g !== exp_seq[n] || f_m_ready === 2'b11) begin
          n_bad++; $display("[TB] FAIL fixed_grant_%0d: got %b expected master %0d", n, f_m_ready, exp_seq[n]);
        end
        n++;
        if (n == 3) f_m_req = 2'b10;
        if (n == 4) f_m_req = 2'b00;
      end
      f_s_ready = f_s_req;
    end
    n_cmp++;
    if (n !== 4) begin n_bad++; $display("[TB] FAIL fixed_count: got %0d expected 4", n); end
    f_m_req = 0; f_s_ready = 0;
    tick(); tick();
  endtask

  task automatic test_write_hold();
    int sc = 0, rc = 0;
    do_reset();
    m_req = 2'b10; m_wen = 2'b10; m_mode = 6'b010_000;
    m_addr = {32'h8000_0010, 32'h0000_0040}; m_wdat = {32'h1234_5678, 32'h0};
    for (int c = 0; c < 20; c++) begin
      tick();
      s_ready = 0;
      if (s_req) begin
        sc++;
        n_cmp++;
        if ({s_wen, s_mode, s_addr, s_wdat, grant_id} !== {1'b1, 3'b010, 32'h8000_0010, 32'h1234_5678, 1'b1}) begin
          n_bad++; $display("[TB] FAIL write_latch_%0d: got %h expected %h", sc,
            {s_wen, s_mode, s_addr, s_wdat, grant_id}, {1'b1, 3'b010, 32'h8000_0010, 32'h1234_5678, 1'b1});
        end
        m_addr[63:32] = 32'hFFFF_FFF0; m_wdat[63:32] = 32'h0BAD_0BAD; m_mode[5:3] = 3'b111; m_wen[1] = 0;
        if (sc == 3) s_ready = 1;
      end
      if (m_ready[1]) begin rc++; m_req = 0; end
    end
    n_cmp++;
    if (sc !== 3 || rc !== 1) begin
      n_bad++; $display("[TB] FAIL write_cycles: got %0d/%0d expected 3/1", sc, rc);
    end
  endtask

  task automatic test_reset_busy();
    int pulses = 0;
    do_reset();
    m_req = 2'b01; m_addr = {32'h0, 32'h8000_0100};
    tick();
    tick();
    n_cmp++;
    if (s_req !== 1'b1) begin n_bad++; $display("[TB] FAIL rstbusy_pre: got %b expected 1", s_req); end
    rst = 1'b0;
    m_req = 0;
    tick();
    n_cmp++;
    if ({s_req, m_ready, s_addr} !== 35'd0) begin
      n_bad++; $display("[TB] FAIL rstbusy_clear: got %h expected 0", {s_req, m_ready, s_addr});
    end
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      s_ready = 1;
      tick();
      if (m_ready != 2'b00) pulses++;
    end
    s_ready = 0;
    n_cmp++;
    if (pulses !== 0) begin n_bad++; $display("[TB] FAIL rstbusy_pulse: got %0d expected 0", pulses); end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int bc = 0, done_c = 0, ok1 = 0;
    do_reset();
    m_req = 2'b01; m_addr = {32'h0, 32'h8000_0200}; s_rdat = 32'hA5A5_A5A5;
    tick();
    s_ready = 1;
    tick();
    s_ready = 0;
    n_cmp++;
    if (m_ready !== 2'b01 || m_rdat[31:0] !== 32'hA5A5_A5A5) begin
      n_bad++; $display("[TB] FAIL timeout_prime: got %b/%h expected 01/a5a5a5a5", m_ready, m_rdat[31:0]);
    end
    for (int c = 0; c < 30; c++) begin
      tick();
      if (s_req) bc++;
      if (m_ready != 2'b00 && done_c == 0) begin
        done_c = 1;
        n_cmp++;
        if ({m_ready, m_err, m_rdat[31:0]} !== {2'b01, 2'b01, 32'h0} || bc !== 4) begin
          n_bad++; $display("[TB] FAIL timeout_abort: got rdy %b err %b rdat %h busy %0d expected 01 01 0 4",
            m_ready, m_err, m_rdat[31:0], bc);
        end
        m_req = 0;
      end
    end
    n_cmp++;
    if (done_c !== 1) begin n_bad++; $display("[TB] FAIL timeout_seen: got %0d expected 1", done_c); end
    m_req = 2'b10; s_rdat = 32'h1357_9BDF;
    for (int c = 0; c < 10; c++) begin
      tick();
      s_ready = s_req;
      if (m_ready[1]) begin
        ok1 = 1; m_req = 0;
        n_cmp++;
        if (m_err !== 2'b00 || m_rdat[63:32] !== 32'h1357_9BDF) begin
          n_bad++; $display("[TB] FAIL timeout_next: got err %b rdat %h expected 00 13579bdf", m_err, m_rdat[63:32]);
        end
      end
    end
    s_ready = 0;
    n_cmp++;
    if (ok1 !== 1) begin n_bad++; $display("[TB] FAIL timeout_next_seen: got %0d expected 1", ok1); end
  endtask
`endif

  task automatic test_random();
    logic        pend[2] = '{0, 0};
    logic        w[2];
    logic [2:0]  md[2];
    logic [31:0] a[2], d[2];
    int          last = 1;
    int          exp_g = 0;
    int          wait_left = 0;
    int          win;
    int          grants = 0;
    logic [31:0] exp_rdat = 0;
    logic [1:0]  req_edge, exp_rdy;
    logic        ready_prev, sreq_prev = 0;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      req_edge = m_req;
      ready_prev = s_ready;
      tick();
      exp_rdy = (ready_prev && sreq_prev) ? ((exp_g == 1) ? 2'b10 : 2'b01) : 2'b00;
      n_cmp++;
      if (m_ready !== exp_rdy) begin
        n_bad++; $display("[TB] FAIL rand_ready cyc %0d: got %b expected %b", c, m_ready, exp_rdy);
      end
      if (exp_rdy != 2'b00) begin
        n_cmp++;
        if (m_rdat[exp_g*32 +: 32] !== exp_rdat || m_err !== 2'b00) begin
          n_bad++; $display("[TB] FAIL rand_rdat cyc %0d: got %h err %b expected %h err 00",
            c, m_rdat[exp_g*32 +: 32], m_err, exp_rdat);
        end
        pend[exp_g] = 0;
        m_req[exp_g] = 0;
        last = exp_g;
      end
      if (s_req && !sreq_prev) begin
        win = (req_edge == 2'b11) ? 1 - last : (req_edge[1] ? 1 : 0);
        grants++;
        n_cmp++;
        if ({grant_id, s_wen, s_mode, s_addr, s_wdat} !== {win[0], w[win], md[win], a[win], d[win]}) begin
          n_bad++; $display("[TB] FAIL rand_grant cyc %0d: got %h expected %h", c,
            {grant_id, s_wen, s_mode, s_addr, s_wdat}, {win[0], w[win], md[win], a[win], d[win]});
        end
        exp_g = win;
        wait_left = $urandom_range(0, 2);
      end
      s_ready = 0;
      if (s_req) begin
        if (wait_left == 0) begin
          s_ready = 1; s_rdat = $urandom; exp_rdat = s_rdat;
        end else begin
          wait_left--;
          s_rdat = $urandom;
        end
      end else begin
        s_ready = 1'($urandom_range(0, 1));
        s_rdat = $urandom;
      end
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1;
          w[i] = 1'($urandom_range(0, 1));
          md[i] = 3'($urandom_range(0, 7));
          a[i] = $urandom;
          d[i] = $urandom;
          m_req[i] = 1; m_wen[i] = w[i];
          m_mode[i*3 +: 3] = md[i]; m_addr[i*32 +: 32] = a[i]; m_wdat[i*32 +: 32] = d[i];
        end
      end
      sreq_prev = s_req;
    end
    n_cmp++;
    if (grants < 50) begin n_bad++; $display("[TB] FAIL rand_grant_count: got %0d expected >= 50", grants); end
    idle_inputs();
    tick(); tick(); tick();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_m0_read();
    test_back_to_back();
    test_fixed_prio();
    test_write_hold();
    test_reset_busy();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
